rx_fifo: RTL and testbench
==========================

// Module: rx_fifo
// PURPOSE
//  Byte FIFO directly downstream of the USB receiver control unit.
//  Captures each decoded byte on the RCU's one-cycle w_enable pulse and holds it for the host-side reader.
//  Reports occupancy, full/empty and sticky overrun/underrun flags.
//  Flushed on demand, e.g. when a packet is aborted by r_error.
// PARAMETERS
//  DEPTH  8  entries; power of two, >=2
//  WIDTH  8  bits per entry (rcv_data width)
// PORTS
//  clk       in   1                single clock, rising edge
//  rst       in   1                synchronous, active-high reset
//  w_enable  in   1                write strobe from RCU, one cycle per byte
//  w_data    in   WIDTH            byte to store (rcv_data)
//  r_enable  in   1                read strobe; pops head entry this cycle
//  clear     in   1                synchronous flush
//  r_data    out  WIDTH            head entry, first-word-fall-through
//  empty     out  1                count==0
//  full      out  1                count==DEPTH
//  count     out  $clog2(DEPTH)+1  entries held
//  overrun   out  1                sticky: a write was dropped
//  underrun  out  1                sticky: a read hit an empty FIFO
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - pointers=0, count=0, empty=1, full=0, overrun=0, underrun=0
//   - r_data=0; storage array contents not reset
//  Pointers:
//   - wptr/rptr are $clog2(DEPTH)+1 bits; MSB is wrap bit, index = low bits
//   - empty when pointers are equal; full when indices match and wrap bits differ
//   - count = wptr-rptr, modulo 2^(ptr width)
//  Write: w_enable & (!full | r_enable) -> mem[widx]<=w_data, wptr+1. Data is visible at r_data the next cycle if the FIFO was empty.
//  Read: r_enable & !empty -> rptr+1. r_data is combinational mem[ridx]; r_data=0 when empty.
//  Simultaneous read+write:
//   - not empty: both performed, count unchanged (also when full)
//   - empty: write performed, read ignored, underrun<=1
//  Write when full without read: data dropped, pointers hold, overrun<=1
//  Read when empty: pointers hold, underrun<=1
//  clear: highest priority after rst.
//   - pointers<=0; overrun, underrun <=0
//   - w_enable/r_enable in the same cycle are ignored
//  Wrap-around: indices roll DEPTH-1 -> 0 and wrap bit toggles; no bubbles.
//  Flags are registered state, derived combinationally from the pointers; no extra latency.
//  Throughput: one write and one read per cycle sustained.
// STRUCTURE
//  Shared package usb_rx_pkg:
//   - BYTE_W=8
//   - SYNC_BYTE=8'b1000_0000
//   - EOP-related constants reused by RCU/timer
//  Sub-module fifo_ptr (instantiated twice):
//   - ptr-width wrap counter with inc and sync clr
//   - outputs full pointer value
//  Top holds storage array, flag logic and sticky error registers.
// TESTING
//  T1 reset: rst=1 two cycles -> empty=1, full=0, count=0, overrun=0, underrun=0, r_data=0
//  T2 fill/drain: write 8'hA5,8'h3C,8'h01 -> count=3, r_data=A5. Three reads -> A5,3C,01 in order, empty=1.
//  T3 full/overrun: write 8 bytes 8'h10..8'h17 -> full=1. Write 8'hFF -> dropped, overrun=1, count=8. Drain returns 10..17.
//  T4 full+simultaneous r/w: at full, read+write 8'h55 -> count stays 8, r_data 10->11, 55 emerges last.
//  T5 empty underrun / simultaneous: read on empty -> underrun=1, count=0. Read+write 8'h77 on empty -> count=1, r_data=77.
//  T6 wrap and clear: 20 interleaved write/read pairs (indices wrap twice, data intact). Then 4 writes, clear with w_enable=1 -> count=0, empty=1, flags cleared.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive path.
// Used by the RCU, EOP timer and the receive byte FIFO.
package usb_rx_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'b1000_0000;

  // EOP is SE0 for two bit times followed by one idle J bit
  localparam int EOP_SE0_BITS = 2;
  localparam int EOP_J_BITS   = 1;
  localparam int BIT_CLKS     = 8;
  localparam int EOP_CLKS     = (EOP_SE0_BITS + EOP_J_BITS) * BIT_CLKS;

  localparam int FIFO_DEPTH = 8;

  typedef struct packed {
    logic empty;
    logic full;
    logic overrun;
    logic underrun;
  } fifo_stat_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer for the receive FIFO.
// Increments on inc; sync reset and clear both return it to zero.
module fifo_ptr
  import usb_rx_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rx_fifo.sv
// Byte FIFO behind the USB receiver control unit.
// First-word-fall-through read, sticky overrun/underrun flags.
module rx_fifo
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_enable,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     r_enable,
  input  logic                     clear,
  output logic [WIDTH-1:0]         r_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;

  logic do_wr;
  logic do_rd;

  logic ovr_q;
  logic ovr_d;
  logic unr_q;
  logic unr_d;

  fifo_stat_t stat;

  assign widx = wptr[AW-1:0];
  assign ridx = rptr[AW-1:0];

  assign stat.empty    = (wptr == rptr);
  assign stat.full     = (widx == ridx) && (wptr[AW] != rptr[AW]);
  assign stat.overrun  = ovr_q;
  assign stat.underrun = unr_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write
  assign do_rd = r_enable && !stat.empty && !clear;
  assign do_wr = w_enable && (!stat.full || r_enable) && !clear;

  fifo_ptr #(.PW(PW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (do_wr),
    .ptr (wptr)
  );

  fifo_ptr #(.PW(PW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (do_rd),
    .ptr (rptr)
  );

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[widx] <= w_data;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    unr_d = unr_q;
    if (clear) begin
      ovr_d = 1'b0;
      unr_d = 1'b0;
    end else begin
      if (w_enable && stat.full && !r_enable) begin
        ovr_d = 1'b1;
      end
      if (r_enable && stat.empty) begin
        unr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
      unr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      unr_q <= unr_d;
    end
  end

  assign r_data   = stat.empty ? '0 : mem_q[ridx];
  assign empty    = stat.empty;
  assign full     = stat.full;
  assign count    = wptr - rptr;
  assign overrun  = stat.overrun;
  assign underrun = stat.underrun;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo.
// Linear step sequence with hand-computed expectations.
module tb_rx_fifo;

  logic       clk;
  logic       rst;
  logic       w_enable;
  logic [7:0] w_data;
  logic       r_enable;
  logic       clear;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic       underrun;

  int errors;
  int checks;

  rx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (r_enable),
    .clear    (clear),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd,
                     input logic re, input logic cl);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    clear    = cl;
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] d);
    chk(tag, {24'd0, r_data}, {24'd0, d});
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    w_enable = 1'b0;
    w_data   = 8'h00;
    r_enable = 1'b0;
    clear    = 1'b0;

    // T1 reset
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_full", {31'd0, full}, 32'd0);
    chk("t1_count", {28'd0, count}, 32'd0);
    chk("t1_ovr", {31'd0, overrun}, 32'd0);
    chk("t1_unr", {31'd0, underrun}, 32'd0);
    chk("t1_rdata", {24'd0, r_data}, 32'd0);

    // T2 fill/drain
    wr(8'hA5);
    chk("t2_fwft", {24'd0, r_data}, 32'hA5);
    wr(8'h3C);
    wr(8'h01);
    chk("t2_count", {28'd0, count}, 32'd3);
    rd_chk("t2_rd0", 8'hA5);
    rd_chk("t2_rd1", 8'h3C);
    rd_chk("t2_rd2", 8'h01);
    chk("t2_empty", {31'd0, empty}, 32'd1);
    chk("t2_unr", {31'd0, underrun}, 32'd0);

    // T3 full/overrun
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + 8'(i));
    end
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_count8", {28'd0, count}, 32'd8);
    chk("t3_ovr0", {31'd0, overrun}, 32'd0);
    wr(8'hFF);
    chk("t3_ovr1", {31'd0, overrun}, 32'd1);
    chk("t3_count_hold", {28'd0, count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_chk("t3_drain", 8'h10 + 8'(i));
    end
    chk("t3_empty", {31'd0, empty}, 32'd1);

    // T4 full with simultaneous read+write
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + 8'(i));
    end
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_head", {24'd0, r_data}, 32'h10);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_count", {28'd0, count}, 32'd8);
    chk("t4_head2", {24'd0, r_data}, 32'h11);
    chk("t4_full2", {31'd0, full}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      rd_chk("t4_drain", 8'h10 + 8'(i));
    end
    rd_chk("t4_last", 8'h55);
    chk("t4_empty", {31'd0, empty}, 32'd1);
    chk("t4_unr", {31'd0, underrun}, 32'd0);

    // T5 underrun and read+write on empty
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_unr", {31'd0, underrun}, 32'd1);
    chk("t5_count0", {28'd0, count}, 32'd0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t5_count1", {28'd0, count}, 32'd1);
    chk("t5_rdata", {24'd0, r_data}, 32'h77);
    rd_chk("t5_pop", 8'h77);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr_ovr", {31'd0, overrun}, 32'd0);
    chk("t5_clr_unr", {31'd0, underrun}, 32'd0);

    // T6 wrap-around and clear
    for (int i = 0; i < 20; i++) begin
      wr(8'h80 + 8'(i));
      chk("t6_cnt1", {28'd0, count}, 32'd1);
      rd_chk("t6_pair", 8'h80 + 8'(i));
    end
    chk("t6_empty", {31'd0, empty}, 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_unr_set", {31'd0, underrun}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      wr(8'hC0 + 8'(i));
    end
    chk("t6_count4", {28'd0, count}, 32'd4);
    chk("t6_head", {24'd0, r_data}, 32'hC0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("t6_clr_count", {28'd0, count}, 32'd0);
    chk("t6_clr_empty", {31'd0, empty}, 32'd1);
    chk("t6_clr_ovr", {31'd0, overrun}, 32'd0);
    chk("t6_clr_unr", {31'd0, underrun}, 32'd0);
    chk("t6_clr_rdata", {24'd0, r_data}, 32'd0);
    wr(8'h42);
    chk("t6_post_clr", {24'd0, r_data}, 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
